// File: rtl/logic_pkg.sv
// ============================================================
// logic_pkg -- op encodings and flag helper for logic_unit_pipe
// Rev 1.0
// ============================================================
`default_nettype none

package logic_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND    = 3'd0;
  localparam op_t OP_OR     = 3'd1;
  localparam op_t OP_XOR    = 3'd2;
  localparam op_t OP_NAND   = 3'd3;
  localparam op_t OP_NOR    = 3'd4;
  localparam op_t OP_NOT    = 3'd5;
  localparam op_t OP_ACC_OR = 3'd6;
  localparam op_t OP_ACC_LD = 3'd7;

  typedef struct packed {
    logic zr;
    logic ng;
  } flags_t;

  // Width-agnostic: caller supplies the OR-reduction and the sign bit.
  function automatic flags_t make_flags(input logic any_set, input logic msb);
    flags_t f;
    f.zr = ~any_set;
    f.ng = msb;
    return f;
  endfunction

endpackage

`default_nettype wire

// File: rtl/logic_unit_pipe_if.sv
// ============================================================
// logic_unit_pipe_if -- input/output handshake bundle
// Rev 1.0
// ============================================================
`default_nettype none

interface logic_unit_pipe_if #(
  parameter int WIDTH = 16
);
  import logic_pkg::*;

  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, out, zr, ng
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, out, zr, ng
  );

endinterface

`default_nettype wire

// File: rtl/logic_op_comb.sv
// ============================================================
// logic_op_comb -- combinational bitwise op / accumulator datapath
// Rev 1.0
// ============================================================
`default_nettype none

module logic_op_comb
  import logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = a & b;
    case (op)
      OP_AND:    result = a & b;
      OP_OR:     result = a | b;
      OP_XOR:    result = a ^ b;
      OP_NAND:   result = ~(a & b);
      OP_NOR:    result = ~(a | b);
      OP_NOT:    result = ~a;
      OP_ACC_OR: result = acc | a;
      OP_ACC_LD: result = a;
      default:   result = a & b;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/logic_unit_pipe.sv
// ============================================================
// logic_unit_pipe -- 2-stage valid/ready bitwise logic unit
// Rev 1.0
// ============================================================
`default_nettype none

module logic_unit_pipe
  import logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  logic_unit_pipe_if.slave  bus
);

  logic             r_s1_valid;
  op_t              r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_out;
  logic             r_zr;
  logic             r_ng;
  logic [WIDTH-1:0] r_acc;

  logic             w_s2_load;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_acc_op;
  logic [WIDTH-1:0] w_result;
  flags_t           w_flags;

  assign w_s2_load  = r_s1_valid && (!r_s2_valid || bus.out_ready);
  assign w_in_ready = !r_s1_valid || w_s2_load;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_acc_op   = (r_s1_op == OP_ACC_OR) || (r_s1_op == OP_ACC_LD);
  assign w_flags    = make_flags(|w_result, w_result[WIDTH-1]);

  logic_op_comb #(.WIDTH(WIDTH)) u_op (
    .op     (r_s1_op),
    .a      (r_s1_a),
    .b      (r_s1_b),
    .acc    (r_acc),
    .result (w_result)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_op    <= OP_AND;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_op    <= bus.op;
      r_s1_a     <= bus.a;
      r_s1_b     <= bus.b;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  // acc moves only when its transaction actually advances into s2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_out      <= '0;
      r_zr       <= 1'b1;
      r_ng       <= 1'b0;
      r_acc      <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= 1'b1;
      r_out      <= w_result;
      r_zr       <= w_flags.zr;
      r_ng       <= w_flags.ng;
      if (w_acc_op) begin
        r_acc <= w_result;
      end
    end else if (bus.out_ready) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_s2_valid;
  assign bus.out       = r_out;
  assign bus.zr        = r_zr;
  assign bus.ng        = r_ng;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
// ============================================================
// tb_logic_unit_pipe -- scoreboard bench for logic_unit_pipe
// Rev 1.0
// ============================================================
`default_nettype none

module tb_logic_unit_pipe;
  import logic_pkg::*;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic_unit_pipe_if #(.WIDTH(WIDTH)) bus ();
  logic_unit_pipe #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb[$];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin : monitor
    logic             prev_stall;
    logic [WIDTH-1:0] prev_out;
    logic [WIDTH-1:0] e;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (bus.out_valid && prev_stall) check("stall_hold", bus.out, prev_out);
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %h with empty scoreboard", bus.out);
          end else begin
            e = sb.pop_front();
            check("out", bus.out, e);
            check_bit("zr", bus.zr, (e == '0));
            check_bit("ng", bus.ng, e[WIDTH-1]);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_out   = bus.out;
      end
    end
  end

  // Must be entered just after a rising edge; returns on the accepting edge.
  task automatic send(input op_t o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH-1:0] exp);
    int n;
    n = 0;
    #1;
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.a        = a;
    bus.b        = b;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 for op %0d", o);
    end
    @(posedge clk);
    if (n < 50) sb.push_back(exp);
  endtask

  task automatic idle();
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    check_bit("out_valid_arrive", bus.out_valid, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = OP_AND;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_bit("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out", bus.out, 16'h0000);
    check_bit("rst_zr", bus.zr, 1'b1);
    check_bit("rst_ng", bus.ng, 1'b0);
    check_bit("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);

    // latency, then the remaining ops streamed
    send(OP_AND, 16'hF0F0, 16'hFF00, 16'hF000);
    idle();
    @(negedge clk);
    check_bit("lat_early", bus.out_valid, 1'b0);
    @(negedge clk);
    check_bit("lat_on", bus.out_valid, 1'b1);
    @(posedge clk);
    send(OP_OR,   16'hF0F0, 16'hFF00, 16'hFFF0);
    send(OP_XOR,  16'hF0F0, 16'hFF00, 16'h0FF0);
    send(OP_NAND, 16'hF0F0, 16'hFF00, 16'h0FFF);
    send(OP_NOR,  16'hF0F0, 16'hFF00, 16'h000F);
    send(OP_NOT,  16'hF0F0, 16'hFF00, 16'h0F0F);
    idle();
    wait_drain();

    @(posedge clk);
    send(OP_AND, 16'h00FF, 16'hFF00, 16'h0000);
    send(OP_OR,  16'h8000, 16'h0000, 16'h8000);
    idle();
    wait_drain();

    @(posedge clk);
    send(OP_ACC_LD, 16'h0001, 16'hFFFF, 16'h0001);
    send(OP_ACC_OR, 16'h0010, 16'hFFFF, 16'h0011);
    send(OP_ACC_OR, 16'h0100, 16'h1234, 16'h0111);
    send(OP_ACC_OR, 16'h8000, 16'h0000, 16'h8111);
    idle();
    wait_drain();

    // backpressure: 5 XORs, downstream stalled for 4 cycles
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(posedge clk);
    fork
      begin
        send(OP_XOR, 16'h1234, 16'h00FF, 16'h12CB);
        send(OP_XOR, 16'hAAAA, 16'h5555, 16'hFFFF);
        send(OP_XOR, 16'hFFFF, 16'hFFFF, 16'h0000);
        send(OP_XOR, 16'h8000, 16'h0001, 16'h8001);
        send(OP_XOR, 16'h0F0F, 16'hF0F0, 16'hFFFF);
        idle();
      end
      begin
        wait_out_valid();
        check_bit("bp_in_ready_full", bus.in_ready, 1'b0);
        repeat (3) @(negedge clk);
        check_bit("bp_in_ready_still", bus.in_ready, 1'b0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();

    // two ACC_ORs queued behind a stall; acc must move once per transaction
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(posedge clk);
    fork
      begin
        send(OP_ACC_OR, 16'h0F00, 16'hFFFF, 16'h8F11);
        send(OP_ACC_OR, 16'h00F0, 16'h0000, 16'h8FF1);
        idle();
      end
      begin
        wait_out_valid();
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    wait_drain();
    @(posedge clk);
    send(OP_ACC_OR, 16'h0000, 16'h5A5A, 16'h8FF1);
    idle();
    wait_drain();

    // asynchronous reset with two items in flight
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(posedge clk);
    send(OP_AND, 16'h1111, 16'hFFFF, 16'h1111);
    send(OP_OR,  16'h0001, 16'h0002, 16'h0003);
    idle();
    @(negedge clk);
    check_bit("mid_out_valid", bus.out_valid, 1'b1);
    check_bit("mid_in_ready", bus.in_ready, 1'b0);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    check_bit("arst_out_valid", bus.out_valid, 1'b0);
    check("arst_out", bus.out, 16'h0000);
    check_bit("arst_zr", bus.zr, 1'b1);
    check_bit("arst_ng", bus.ng, 1'b0);
    check_bit("arst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #3;
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_bit("post_rst_out_valid", bus.out_valid, 1'b0);
      check_bit("post_rst_in_ready", bus.in_ready, 1'b1);
    end
    @(posedge clk);
    send(OP_ACC_OR, 16'h0000, 16'hFFFF, 16'h0000);
    idle();
    wait_drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
